// File: rtl/fpga_instr_serializer.sv
// fpga_instr_serializer
// Buffers wide instructions in a FIFO and sends each one to the board as
// CHUNK_W-bit words over an asynchronous four-phase req/ack handshake.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   instr_valid     write strobe for instr_data
//   instr_data      INSTR_W-bit instruction
//   fifo_full       FIFO holds FIFO_DEPTH entries
//   fifo_count      current FIFO occupancy
//   overflow        sticky: write attempted while full
//   chunk_req       request to the board
//   chunk_data      chunk payload, stable while the handshake is in flight
//   chunk_ack       asynchronous acknowledge from the board
//   busy            FSM is not idle
//   timeout_err     sticky: an ack phase exceeded ACK_TIMEOUT cycles
//   err_clr         single-cycle clear of overflow and timeout_err
//   sent_count      fully delivered instructions, wraps at 2^16
module fpga_instr_serializer #(
  parameter int INSTR_W     = 147,
  parameter int CHUNK_W     = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          instr_valid,
  input  logic [INSTR_W-1:0]            instr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          chunk_req,
  output logic [CHUNK_W-1:0]            chunk_data,
  input  logic                          chunk_ack,
  output logic                          busy,
  output logic                          timeout_err,
  input  logic                          err_clr,
  output logic [15:0]                   sent_count
);

  localparam int NUM_CHUNKS = (INSTR_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_W;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int TO_W       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int TO_LIM     = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

  localparam logic [IDX_W-1:0] FIRST_IDX = (MSB_FIRST != 0) ? IDX_W'(NUM_CHUNKS - 1) : IDX_W'(0);
  localparam logic [IDX_W-1:0] LAST_IDX  = (MSB_FIRST != 0) ? IDX_W'(0) : IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DRIVE   = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_ABORT   = 3'd5
  } state_t;

  state_t                   state_r;
  state_t                   state_nx;

  logic [INSTR_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic [CNT_W-1:0]         count_nx;
  logic                     full_r;
  logic                     wr_en_s;
  logic                     pop_s;

  logic [SYNC_STAGES-1:0]   sync_r;
  logic                     ack_s;

  logic [PAD_W-1:0]         instr_r;
  logic [IDX_W-1:0]         idx_r;
  logic [IDX_W-1:0]         idx_nx;
  logic [TO_W-1:0]          phase_r;
  logic                     to_hit_s;
  logic                     waiting_s;

  logic                     req_clr_s;
  logic                     adv_s;
  logic                     done_s;
  logic                     to_set_s;

  logic                     req_r;
  logic [CHUNK_W-1:0]       data_r;
  logic                     busy_r;
  logic                     ovf_r;
  logic                     to_err_r;
  logic [15:0]              sent_r;

  assign fifo_full   = full_r;
  assign fifo_count  = count_r;
  assign overflow    = ovf_r;
  assign chunk_req   = req_r;
  assign chunk_data  = data_r;
  assign busy        = busy_r;
  assign timeout_err = to_err_r;
  assign sent_count  = sent_r;

  // A full FIFO blocks the write even when a pop happens in the same cycle.
  assign wr_en_s   = instr_valid & ~full_r;
  assign pop_s     = (state_r == S_LOAD);
  assign ack_s     = sync_r[SYNC_STAGES-1];
  assign waiting_s = (state_r == S_WAIT_HI) || (state_r == S_WAIT_LO);
  assign to_hit_s  = (ACK_TIMEOUT > 0) && (phase_r == TO_W'(TO_LIM));

  // FIFO occupancy and next chunk index
  always_comb begin
    count_nx = count_r;
    idx_nx   = idx_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nx = count_r + CNT_W'(1);
      2'b01:   count_nx = count_r - CNT_W'(1);
      default: count_nx = count_r;
    endcase
    if (MSB_FIRST != 0) begin
      idx_nx = idx_r - IDX_W'(1);
    end else begin
      idx_nx = idx_r + IDX_W'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_r] <= instr_data;
    end
  end

  // FIFO pointers, occupancy and full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nx;
      full_r  <= (count_nx == CNT_W'(FIFO_DEPTH));
    end
  end

  // chunk_ack synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], chunk_ack};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next state and handshake control strobes
  always_comb begin
    state_nx  = state_r;
    req_clr_s = 1'b0;
    adv_s     = 1'b0;
    done_s    = 1'b0;
    to_set_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != CNT_W'(0)) state_nx = S_LOAD;
        else                      state_nx = S_IDLE;
      end
      S_LOAD:  state_nx = S_DRIVE;
      S_DRIVE: state_nx = S_WAIT_HI;
      S_WAIT_HI: begin
        if (ack_s) begin
          req_clr_s = 1'b1;
          state_nx  = S_WAIT_LO;
        end else if (to_hit_s) begin
          // Drop the request at once rather than a cycle later in ABORT.
          to_set_s  = 1'b1;
          req_clr_s = 1'b1;
          state_nx  = S_ABORT;
        end else begin
          state_nx  = S_WAIT_HI;
        end
      end
      S_WAIT_LO: begin
        if (!ack_s) begin
          if (idx_r == LAST_IDX) begin
            done_s   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            adv_s    = 1'b1;
            state_nx = S_DRIVE;
          end
        end else if (to_hit_s) begin
          to_set_s = 1'b1;
          state_nx = S_ABORT;
        end else begin
          state_nx = S_WAIT_LO;
        end
      end
      S_ABORT: begin
        // Wait for the board to release ack; the rest of the instruction is discarded.
        req_clr_s = 1'b1;
        if (!ack_s) state_nx = S_IDLE;
        else        state_nx = S_ABORT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-phase cycle counter, cleared on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= '0;
    end else if ((state_nx != state_r) || !waiting_s) begin
      phase_r <= '0;
    end else begin
      phase_r <= phase_r + TO_W'(1);
    end
  end

  // Instruction shift register and chunk index
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r <= '0;
      idx_r   <= '0;
    end else if (pop_s) begin
      instr_r <= PAD_W'(mem[rd_ptr_r]);
      idx_r   <= FIRST_IDX;
    end else if (adv_s) begin
      idx_r   <= idx_nx;
    end else begin
      idx_r   <= idx_r;
    end
  end

  // Handshake outputs: data only changes in DRIVE, so it is stable while req is up
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r  <= 1'b0;
      data_r <= '0;
    end else if (state_r == S_DRIVE) begin
      req_r  <= 1'b1;
      data_r <= instr_r[int'(idx_r) * CHUNK_W +: CHUNK_W];
    end else if (req_clr_s) begin
      req_r  <= 1'b0;
    end else begin
      req_r  <= req_r;
    end
  end

  // Status: busy, sticky errors (a set beats a same-cycle clear), delivery counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      to_err_r <= 1'b0;
      sent_r   <= 16'd0;
    end else begin
      busy_r   <= (state_nx != S_IDLE);
      ovf_r    <= (instr_valid & full_r) | (ovf_r & ~err_clr);
      to_err_r <= to_set_s | (to_err_r & ~err_clr);
      if (done_s) sent_r <= sent_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_fpga_instr_serializer.sv
// Self-checking bench for fpga_instr_serializer. Instance A uses the default
// parameters; instance B uses MSB_FIRST=0, FIFO_DEPTH=4, ACK_TIMEOUT=20.
module tb_fpga_instr_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Instance A signals
  logic         rst_a, instr_valid_a, err_clr_a, chunk_ack_a;
  logic [146:0] instr_data_a;
  logic         fifo_full_a, overflow_a, chunk_req_a, busy_a, timeout_err_a;
  logic [4:0]   fifo_count_a;
  logic [31:0]  chunk_data_a;
  logic [15:0]  sent_count_a;

  // Instance B signals
  logic         rst_b, instr_valid_b, err_clr_b, chunk_ack_b;
  logic [146:0] instr_data_b;
  logic         fifo_full_b, overflow_b, chunk_req_b, busy_b, timeout_err_b;
  logic [2:0]   fifo_count_b;
  logic [31:0]  chunk_data_b;
  logic [15:0]  sent_count_b;

  fpga_instr_serializer u_a (
    .clk(clk), .rst(rst_a), .instr_valid(instr_valid_a), .instr_data(instr_data_a),
    .fifo_full(fifo_full_a), .fifo_count(fifo_count_a), .overflow(overflow_a),
    .chunk_req(chunk_req_a), .chunk_data(chunk_data_a), .chunk_ack(chunk_ack_a),
    .busy(busy_a), .timeout_err(timeout_err_a), .err_clr(err_clr_a),
    .sent_count(sent_count_a)
  );

  fpga_instr_serializer #(.MSB_FIRST(0), .FIFO_DEPTH(4), .ACK_TIMEOUT(20)) u_b (
    .clk(clk), .rst(rst_b), .instr_valid(instr_valid_b), .instr_data(instr_data_b),
    .fifo_full(fifo_full_b), .fifo_count(fifo_count_b), .overflow(overflow_b),
    .chunk_req(chunk_req_b), .chunk_data(chunk_data_b), .chunk_ack(chunk_ack_b),
    .busy(busy_b), .timeout_err(timeout_err_b), .err_clr(err_clr_b),
    .sent_count(sent_count_b)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: chunk k is bits [k*32 +: 32] of the zero-extended instruction.
  function automatic logic [31:0] chunk_of(input logic [146:0] v, input int k);
    logic [159:0] ext;
    ext = 160'(v) >> (k * 32);
    return ext[31:0];
  endfunction

  function automatic int send_k(input int i, input bit msb_first);
    return msb_first ? (4 - i) : i;
  endfunction

  // Board models: echo req onto ack after dly cycles
  bit en_a = 1'b0, en_b = 1'b0, rand_a = 1'b0;
  int dly_a = 4, dly_b = 4;

  always begin
    @(posedge clk); #2;
    if (en_a && (chunk_req_a !== chunk_ack_a)) begin
      if (rand_a) dly_a = $urandom_range(0, 4);
      repeat (dly_a) @(posedge clk);
      #2;
      if (en_a) chunk_ack_a = chunk_req_a;
    end
  end

  always begin
    @(posedge clk); #2;
    if (en_b && (chunk_req_b !== chunk_ack_b)) begin
      repeat (dly_b) @(posedge clk);
      #2;
      if (en_b) chunk_ack_b = chunk_req_b;
    end
  end

  // Monitors: capture each chunk on req rise, check payload stays stable while req is up
  logic [31:0] got_a[$], got_b[$];
  logic [31:0] last_a = 32'd0;
  logic        prev_a = 1'b0, prev_b = 1'b0;
  int          rise_cyc_b = 0;

  always begin
    @(posedge clk); #1;
    if (chunk_req_a && !prev_a) begin
      got_a.push_back(chunk_data_a);
      last_a = chunk_data_a;
    end else if (chunk_req_a) begin
      check("stable_a", 160'(chunk_data_a), 160'(last_a));
    end
    prev_a = chunk_req_a;
  end

  always begin
    @(posedge clk); #1;
    if (chunk_req_b && !prev_b) begin
      got_b.push_back(chunk_data_b);
      rise_cyc_b = cyc;
    end
    prev_b = chunk_req_b;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_a(input logic [146:0] d);
    instr_valid_a = 1'b1; instr_data_a = d;
    tick();
    instr_valid_a = 1'b0;
  endtask

  task automatic write_b(input logic [146:0] d);
    instr_valid_b = 1'b1; instr_data_b = d;
    tick();
    instr_valid_b = 1'b0;
  endtask

  task automatic wait_got_a(input int n, input int bound, input string name);
    int t = 0;
    while (got_a.size() < n && t < bound) begin tick(); t++; end
    if (got_a.size() < n) bound_fail(name);
  endtask

  task automatic wait_got_b(input int n, input int bound, input string name);
    int t = 0;
    while (got_b.size() < n && t < bound) begin tick(); t++; end
    if (got_b.size() < n) bound_fail(name);
  endtask

  task automatic wait_idle_a(input string name);
    int t = 0;
    while (busy_a && t < 200) begin tick(); t++; end
    if (busy_a) bound_fail(name);
  endtask

  task automatic wait_idle_b(input string name);
    int t = 0;
    while (busy_b && t < 200) begin tick(); t++; end
    if (busy_b) bound_fail(name);
  endtask

  function automatic logic [146:0] rand_instr();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[146:0];
  endfunction

  typedef struct {
    logic [146:0] instr;
    logic [159:0] exp_msb;  // first-sent chunk in [159:128]
    logic [159:0] exp_lsb;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] exp_q[$];
  logic [146:0] wb[6];

  initial begin
    logic [159:0] e;
    logic [146:0] d;
    int t;
    int written;

    vecs[0].instr   = 147'h5ABCD_11111111_22222222_33333333_44444444;
    vecs[0].exp_msb = {32'h0005ABCD, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    vecs[0].exp_lsb = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 32'h0005ABCD};
    vecs[1].instr   = '1;
    vecs[1].exp_msb = {32'h0007FFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[1].exp_lsb = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0007FFFF};
    vecs[2].instr   = 147'd1;
    vecs[2].exp_msb = {32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    vecs[2].exp_lsb = {32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3].instr   = {1'b1, 146'd0};
    vecs[3].exp_msb = {32'h00040000, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[3].exp_lsb = {32'h0, 32'h0, 32'h0, 32'h0, 32'h00040000};

    rst_a = 1'b1; instr_valid_a = 1'b0; instr_data_a = '0; err_clr_a = 1'b0; chunk_ack_a = 1'b0;
    rst_b = 1'b1; instr_valid_b = 1'b0; instr_data_b = '0; err_clr_b = 1'b0; chunk_ack_b = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    check("rst_req",      160'(chunk_req_a),   160'd0);
    check("rst_data",     160'(chunk_data_a),  160'd0);
    check("rst_busy",     160'(busy_a),        160'd0);
    check("rst_full",     160'(fifo_full_a),   160'd0);
    check("rst_count",    160'(fifo_count_a),  160'd0);
    check("rst_ovf",      160'(overflow_a),    160'd0);
    check("rst_to",       160'(timeout_err_a), 160'd0);
    check("rst_sent",     160'(sent_count_a),  160'd0);

    // Table vectors, MSB first on A
    en_a = 1'b1; dly_a = 4;
    for (int v = 0; v < 4; v++) begin
      got_a.delete();
      write_a(vecs[v].instr);
      wait_got_a(5, 300, "vec_a_chunks");
      wait_idle_a("vec_a_idle");
      e = vecs[v].exp_msb;
      for (int i = 0; i < 5; i++) begin
        if (i < got_a.size()) check($sformatf("vec_a%0d_c%0d", v, i), 160'(got_a[i]), 160'(e[159 - i*32 -: 32]));
      end
      check($sformatf("vec_a%0d_sent", v), 160'(sent_count_a), 160'(v + 1));
      check($sformatf("vec_a%0d_busy", v), 160'(busy_a), 160'd0);
    end

    // Table vectors, LSB first on B
    en_b = 1'b1; dly_b = 4;
    for (int v = 0; v < 4; v++) begin
      got_b.delete();
      write_b(vecs[v].instr);
      wait_got_b(5, 300, "vec_b_chunks");
      wait_idle_b("vec_b_idle");
      e = vecs[v].exp_lsb;
      for (int i = 0; i < 5; i++) begin
        if (i < got_b.size()) check($sformatf("vec_b%0d_c%0d", v, i), 160'(got_b[i]), 160'(e[159 - i*32 -: 32]));
      end
      check($sformatf("vec_b%0d_sent", v), 160'(sent_count_b), 160'(v + 1));
      check($sformatf("vec_b%0d_to", v), 160'(timeout_err_b), 160'd0);
    end

    // Reset while in WAIT_LO of chunk 2 with a second instruction queued
    got_a.delete();
    write_a(vecs[0].instr);
    write_a(vecs[1].instr);
    wait_got_a(3, 300, "rst_mid_chunks");
    t = 0;
    while (chunk_req_a && t < 100) begin tick(); t++; end
    if (chunk_req_a) bound_fail("rst_mid_req_fall");
    check("rst_mid_pre_count", 160'(fifo_count_a), 160'd1);
    rst_a = 1'b1; en_a = 1'b0; chunk_ack_a = 1'b0;
    tick();
    check("rst_mid_req",   160'(chunk_req_a),  160'd0);
    check("rst_mid_count", 160'(fifo_count_a), 160'd0);
    check("rst_mid_sent",  160'(sent_count_a), 160'd0);
    check("rst_mid_busy",  160'(busy_a),       160'd0);
    rst_a = 1'b0;

    // B: fill, overflow, sticky clear; ack held low
    en_b = 1'b0; chunk_ack_b = 1'b0; rst_b = 1'b1;
    repeat (2) tick();
    rst_b = 1'b0;
    got_b.delete();
    for (int i = 0; i < 6; i++) wb[i] = rand_instr();
    for (int i = 0; i < 4; i++) write_b(wb[i]);
    check("fill_count3", 160'(fifo_count_b), 160'd3);
    check("fill_full3",  160'(fifo_full_b),  160'd0);
    write_b(wb[4]);
    check("fill_count4", 160'(fifo_count_b), 160'd4);
    check("fill_full4",  160'(fifo_full_b),  160'd1);
    check("fill_ovf0",   160'(overflow_b),   160'd0);
    write_b(wb[5]);
    check("ovf_set",     160'(overflow_b),   160'd1);
    check("ovf_count",   160'(fifo_count_b), 160'd4);
    err_clr_b = 1'b1; instr_valid_b = 1'b1; instr_data_b = wb[5];
    tick();
    err_clr_b = 1'b0; instr_valid_b = 1'b0;
    check("ovf_set_wins", 160'(overflow_b), 160'd1);
    err_clr_b = 1'b1;
    tick();
    err_clr_b = 1'b0;
    check("ovf_clr", 160'(overflow_b), 160'd0);

    // B: timeout in WAIT_HI, abort, next instruction from its first chunk
    t = 0;
    while (!timeout_err_b && t < 100) begin tick(); t++; end
    if (!timeout_err_b) bound_fail("to_wait");
    check("to_cycles", 160'(cyc - rise_cyc_b), 160'd20);
    check("to_req",    160'(chunk_req_b),      160'd0);
    check("to_first",  160'(got_b.size() > 0 ? got_b[0] : 32'hDEADBEEF), 160'(chunk_of(wb[0], send_k(0, 1'b0))));
    wait_got_b(2, 50, "to_restart");
    if (got_b.size() > 1) check("to_restart_c0", 160'(got_b[1]), 160'(chunk_of(wb[1], send_k(0, 1'b0))));
    check("to_sticky", 160'(timeout_err_b), 160'd1);
    check("to_sent",   160'(sent_count_b),  160'd0);
    err_clr_b = 1'b1;
    tick();
    err_clr_b = 1'b0;
    check("to_clr", 160'(timeout_err_b), 160'd0);

    // A: 8 back-to-back instructions with zero-delay ack
    en_a = 1'b1; dly_a = 0;
    got_a.delete(); exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      d = rand_instr();
      for (int i = 0; i < 5; i++) exp_q.push_back(chunk_of(d, send_k(i, 1'b1)));
      write_a(d);
    end
    wait_got_a(40, 3000, "b2b_chunks");
    wait_idle_a("b2b_idle");
    for (int i = 0; i < 40; i++) begin
      if (i < got_a.size()) check($sformatf("b2b_c%0d", i), 160'(got_a[i]), 160'(exp_q[i]));
    end
    check("b2b_sent", 160'(sent_count_a), 160'd8);
    check("b2b_ovf",  160'(overflow_a),   160'd0);

    // A: random traffic and random ack delays against the model
    rst_a = 1'b1; en_a = 1'b0; chunk_ack_a = 1'b0;
    repeat (2) tick();
    rst_a = 1'b0;
    en_a = 1'b1; rand_a = 1'b1;
    got_a.delete(); exp_q.delete();
    written = 0;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 5)) tick();
      t = 0;
      while ((written - got_a.size() / 5) >= 12 && t < 2000) begin tick(); t++; end
      d = rand_instr();
      for (int i = 0; i < 5; i++) exp_q.push_back(chunk_of(d, send_k(i, 1'b1)));
      write_a(d);
      written++;
    end
    wait_got_a(150, 20000, "rand_chunks");
    wait_idle_a("rand_idle");
    for (int i = 0; i < 150; i++) begin
      if (i < got_a.size()) check($sformatf("rand_c%0d", i), 160'(got_a[i]), 160'(exp_q[i]));
    end
    check("rand_sent", 160'(sent_count_a), 160'd30);
    check("rand_ovf",  160'(overflow_a),   160'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
